psu_count_monitor: RTL and testbench
====================================

Name: psu_count_monitor

Overview:
- Digital-domain consumer of the 4-bit free-running count produced by the adjustable-PSU counter macro.
- That count is asynchronous to this block's clock and is binary, not Gray-coded.
- The block synchronises and de-glitches the count, then extends it into a wide running total.
- It also measures events per fixed gate window, so firmware or the TT outputs can read counter activity and PSU-dependent rate without sampling the analog pins directly.

Parameters:
- STABLE_CYCLES, 2: consecutive clk cycles a synchronised value must hold before it is accepted (1..15).
- GATE_CYCLES, 1000: length of the rate-measurement window in clk cycles (2..65535).
- MAX_STEP, 4: largest legal modulo-16 increment between accepted values; larger increments are errors.
- TOTAL_W, 16: width of the running total.
- RATE_W, 12: width of the per-window rate result.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- count_in  input  4  raw count from the counter macro; asynchronous to clk.
- clear  input  1  synchronous clear of total, rate window and sticky flags.
- total  output  TOTAL_W  accumulated event count, modulo 2^TOTAL_W.
- rate  output  RATE_W  events counted in the last complete gate window.
- rate_valid  output  1  one-cycle pulse when rate updates.
- step_err  output  1  sticky: an increment larger than MAX_STEP was seen.
- total_ovf  output  1  sticky: total wrapped past 2^TOTAL_W-1.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high.
- Reset forces all of the following to 0: total, rate, rate_valid, step_err, total_ovf, sync flops, cand, stab, acc_val, primed, gate counter and window accumulator.
- Synchroniser: count_in passes through two flops (s1, s2).
- Filter:
  - If s2 != cand: cand<=s2 and stab<=0.
  - Otherwise stab increments, saturating at STABLE_CYCLES.
- Accept condition: stab==STABLE_CYCLES and cand!=acc_val. On accept, acc_val<=cand.
- Baseline: if primed==0, the first accept only loads acc_val and sets primed. No delta is added. The counter's value at reset is unknown.
- Delta on a primed accept: delta = (cand - acc_val) mod 16, range 1..15. The wrap 15->0 gives delta 1.
- If delta <= MAX_STEP:
  - total<=total+delta, modulo 2^TOTAL_W.
  - total_ovf is set if the addition carries out.
- If delta > MAX_STEP: step_err is set, total is unchanged, and acc_val still resynchronises to cand.
- Latency: count the first clk edge sampling a new count_in value as edge 0. total reflects it after edge STABLE_CYCLES+3 (edge 5 at default).
- A bouncing input that never holds STABLE_CYCLES cycles is never accepted.
- Gate counter: runs 0..GATE_CYCLES-1 continuously from reset or clear.
- Window accumulator: adds each legal delta, saturating at 2^RATE_W-1.
- On gate counter == GATE_CYCLES-1:
  - rate<=saturate(window accumulator + legal delta of this cycle).
  - rate_valid=1 for exactly that following cycle.
  - The window accumulator restarts at 0 and the gate counter wraps to 0.
- clear (synchronous, precedence over everything except reset) zeroes:
  - total, step_err, total_ovf;
  - the gate counter and window accumulator;
  - rate_valid for that cycle.
- clear does not change rate, acc_val, primed or the filter. A delta accepted in the same cycle as clear is discarded.
- reset asserted mid-window aborts the window; no rate_valid is produced.

Test Plan:
- Reset, then hold count_in=7 for 10 cycles -> baseline only; total=0, step_err=0, primed internally set.
- From baseline 7, step count_in 8,9,...,15,0,1 with each held 20 cycles -> total=10. Each update lands 5 edges after the sampling edge. The 15->0 wrap counts as 1.
- With baseline 3, jump count_in to 12 -> step_err=1, total unchanged. Then 13 -> total+=1, step_err stays 1.
- Toggle count_in between 4 and 5 every cycle for 50 cycles (STABLE_CYCLES=2), then settle at 5 -> no update during the toggling. A single +1 occurs only if the settle value differs from acc_val.
- GATE_CYCLES=100, increment the count by 1 every 10 cycles -> rate_valid pulses every 100 cycles with rate=10. Also set total=2^16-2 via prior steps and add 3 -> total=1, total_ovf=1.
- Assert clear on the same cycle as an accept -> delta discarded, total=0, flags cleared, next window full GATE_CYCLES long. Assert reset mid-window -> all outputs 0, no rate_valid.

Source files
------------

// File: rtl/psu_count_monitor.sv
// psu_count_monitor
//
// Consumes the 4-bit free-running binary count of the adjustable-PSU counter
// macro. That count is asynchronous to clk. The block synchronises it,
// de-glitches it and extends it into a wide running total. It also measures
// how many events land in each fixed gate window, which gives the PSU-dependent
// rate.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   count_in    raw 4-bit count from the counter macro (asynchronous to clk)
//   clear       synchronous clear of total, rate window and sticky flags
//   total       accumulated event count, modulo 2^TOTAL_W
//   rate        events counted in the last complete gate window (saturating)
//   rate_valid  one-cycle pulse when rate updates
//   step_err    sticky: an accepted increment exceeded MAX_STEP
//   total_ovf   sticky: total wrapped past 2^TOTAL_W-1
//
// Parameters:
//   STABLE_CYCLES  cycles a synchronised value must hold before it is accepted (1..15)
//   GATE_CYCLES    rate window length in clk cycles (2..65535)
//   MAX_STEP       largest legal modulo-16 increment between accepted values
//   TOTAL_W        running total width (>= 4)
//   RATE_W         rate result width (>= 4)

module psu_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int GATE_CYCLES   = 1000,
  parameter int MAX_STEP      = 4,
  parameter int TOTAL_W       = 16,
  parameter int RATE_W        = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         count_in,
  input  logic               clear,
  output logic [TOTAL_W-1:0] total,
  output logic [RATE_W-1:0]  rate,
  output logic               rate_valid,
  output logic               step_err,
  output logic               total_ovf
);

  localparam int                GATE_W     = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [3:0]        STABLE_C   = 4'(STABLE_CYCLES);
  // A MAX_STEP of 15 or more makes every non-zero increment legal.
  localparam logic [4:0]        MAX_STEP_C = (MAX_STEP >= 15) ? 5'd15 : 5'(MAX_STEP);
  localparam logic [RATE_W-1:0] RATE_MAX   = {RATE_W{1'b1}};

  // Adds a 4-bit delta to the window accumulator. The sum clamps at the
  // largest value that rate can hold.
  function automatic logic [RATE_W-1:0] sat_add(input logic [RATE_W-1:0] acc,
                                                input logic [3:0]        delta);
    logic [RATE_W:0] sum;
    sum = {1'b0, acc} + {{(RATE_W-3){1'b0}}, delta};
    if (sum[RATE_W]) begin
      return RATE_MAX;
    end else begin
      return sum[RATE_W-1:0];
    end
  endfunction

  logic [3:0]        s1_r;
  logic [3:0]        s2_r;
  logic [3:0]        cand_r;
  logic [3:0]        stab_r;
  logic [3:0]        acc_val_r;
  logic              primed_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [RATE_W-1:0] win_acc_r;

  logic              accept_s;
  logic [3:0]        delta_s;
  logic              legal_s;
  logic              illegal_s;
  logic [3:0]        legal_delta_s;
  logic [TOTAL_W:0]  total_sum_s;
  logic [RATE_W-1:0] win_next_s;
  logic              gate_end_s;

  // Two-flop synchroniser. The count is binary, so s2_r can briefly show
  // an incoherent mix of old and new bits. The stability filter downstream
  // rejects such a value because it does not persist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= 4'd0;
      s2_r <= 4'd0;
    end else begin
      s1_r <= count_in;
      s2_r <= s1_r;
    end
  end

  // Stability filter: restart the hold count whenever the synchronised value
  // changes. Otherwise count up to STABLE_CYCLES and stay there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_r <= 4'd0;
      stab_r <= 4'd0;
    end else if (s2_r != cand_r) begin
      cand_r <= s2_r;
      stab_r <= 4'd0;
    end else if (stab_r != STABLE_C) begin
      cand_r <= cand_r;
      stab_r <= stab_r + 4'd1;
    end else begin
      cand_r <= cand_r;
      stab_r <= stab_r;
    end
  end

  // Accept decision and classification of the modulo-16 increment.
  always_comb begin
    accept_s  = (stab_r == STABLE_C) && (cand_r != acc_val_r);
    delta_s   = cand_r - acc_val_r;
    legal_s   = 1'b0;
    illegal_s = 1'b0;
    if (accept_s && primed_r) begin
      if ({1'b0, delta_s} <= MAX_STEP_C) begin
        legal_s = 1'b1;
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      legal_s   = 1'b0;
      illegal_s = 1'b0;
    end
    legal_delta_s = legal_s ? delta_s : 4'd0;
  end

  // Last accepted value. The first accept after reset only establishes the
  // baseline, because the counter value at reset is unknown. clear has no
  // effect here, so the value stays tracked across a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_val_r <= 4'd0;
      primed_r  <= 1'b0;
    end else if (accept_s) begin
      acc_val_r <= cand_r;
      primed_r  <= 1'b1;
    end else begin
      acc_val_r <= acc_val_r;
      primed_r  <= primed_r;
    end
  end

  // Running-total adder. The extra top bit is the wrap-around carry.
  always_comb begin
    total_sum_s = {1'b0, total} + {{(TOTAL_W-3){1'b0}}, legal_delta_s};
  end

  // Running total and sticky flags. clear wins, so a delta accepted in the
  // same cycle as clear is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total     <= '0;
      total_ovf <= 1'b0;
      step_err  <= 1'b0;
    end else if (clear) begin
      total     <= '0;
      total_ovf <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      if (legal_s) begin
        total     <= total_sum_s[TOTAL_W-1:0];
        total_ovf <= total_ovf | total_sum_s[TOTAL_W];
      end else begin
        total     <= total;
        total_ovf <= total_ovf;
      end
      step_err <= step_err | illegal_s;
    end
  end

  // Next window accumulator value and end-of-window detection.
  always_comb begin
    win_next_s = sat_add(win_acc_r, legal_delta_s);
    gate_end_s = (gate_cnt_r == GATE_LAST);
  end

  // Gate window. The delta that lands on the last cycle of a window still
  // belongs to that window, so it is folded into the published rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_cnt_r <= '0;
      win_acc_r  <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else if (clear) begin
      gate_cnt_r <= '0;
      win_acc_r  <= '0;
      rate       <= rate;
      rate_valid <= 1'b0;
    end else if (gate_end_s) begin
      gate_cnt_r <= '0;
      win_acc_r  <= '0;
      rate       <= win_next_s;
      rate_valid <= 1'b1;
    end else begin
      gate_cnt_r <= gate_cnt_r + GATE_W'(1);
      win_acc_r  <= win_next_s;
      rate       <= rate;
      rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psu_count_monitor.sv
module tb_psu_count_monitor;

  localparam int S    = 2;
  localparam int G    = 100;
  localparam int MAXS = 4;
  localparam int TMOD = 65536;
  localparam int RMAX = 4095;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  count_in;
  logic        clear;
  logic [15:0] total;
  logic [11:0] rate;
  logic        rate_valid;
  logic        step_err;
  logic        total_ovf;

  psu_count_monitor #(
    .STABLE_CYCLES(S),
    .GATE_CYCLES  (G),
    .MAX_STEP     (MAXS),
    .TOTAL_W      (16),
    .RATE_W       (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .clear     (clear),
    .total     (total),
    .rate      (rate),
    .rate_valid(rate_valid),
    .step_err  (step_err),
    .total_ovf (total_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int tq[$];   // cycle numbers of rate_valid pulses
  int rq[$];   // rate value at each pulse

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural reference model ----------------
  // The model keeps the recent raw samples of count_in. A value is accepted
  // once it appears in S+1 consecutive samples. The accepted update becomes
  // visible three edges after the last of those samples: two edges for the
  // synchroniser and one for the registered result.
  int m_total = 0, m_rate = 0, m_rv = 0, m_err = 0, m_ovf = 0;
  int m_gate = 0, m_win = 0, m_acc = 0, m_primed = 0;
  int hist[$];

  task automatic model_reset();
    m_total = 0; m_rate = 0; m_rv = 0; m_err = 0; m_ovf = 0;
    m_gate = 0; m_win = 0; m_acc = 0; m_primed = 0;
    hist.delete();
    // After reset the pipeline holds zeros. They act as three earlier samples.
    hist.push_back(0); hist.push_back(0); hist.push_back(0);
  endtask

  task automatic model_step(input int cin, input bit clr);
    int val, d, ld, n;
    bit run, legal, illegal;
    d = 0; ld = 0; legal = 1'b0; illegal = 1'b0;
    n = hist.size();
    if (n >= S + 3) begin
      val = hist[n-3];
      run = 1'b1;
      for (int i = 0; i <= S; i++) if (hist[n-3-i] != val) run = 1'b0;
      if (run && val != m_acc) begin
        if (m_primed == 0) m_primed = 1;
        else begin
          d = (val - m_acc + 16) % 16;
          if (d <= MAXS) legal = 1'b1; else illegal = 1'b1;
        end
        m_acc = val;
      end
    end
    hist.push_back(cin);
    while (hist.size() > S + 3) void'(hist.pop_front());
    if (clr) begin
      m_total = 0; m_err = 0; m_ovf = 0; m_gate = 0; m_win = 0; m_rv = 0;
    end else begin
      if (legal) begin
        ld = d;
        m_total += d;
        if (m_total >= TMOD) begin m_total -= TMOD; m_ovf = 1; end
      end
      if (illegal) m_err = 1;
      if (m_gate == G - 1) begin
        m_rate = (m_win + ld > RMAX) ? RMAX : m_win + ld;
        m_rv = 1; m_gate = 0; m_win = 0;
      end else begin
        m_win = (m_win + ld > RMAX) ? RMAX : m_win + ld;
        m_rv = 0; m_gate++;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step(int'(count_in), clear);
  end

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rate_valid === 1'b1) begin
      tq.push_back(cyc);
      rq.push_back(int'(rate));
    end
    if (chk_en) begin
      check("total",      int'(total),      m_total);
      check("rate",       int'(rate),       m_rate);
      check("rate_valid", int'(rate_valid), m_rv);
      check("step_err",   int'(step_err),   m_err);
      check("total_ovf",  int'(total_ovf),  m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input int v, input int n);
    count_in = 4'(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_total"}, int'(total), 0);
    check({tag, "_rate"},  int'(rate),  0);
    check({tag, "_rv"},    int'(rate_valid), 0);
    check({tag, "_err"},   int'(step_err),   0);
    check({tag, "_ovf"},   int'(total_ovf),  0);
  endtask

  initial begin
    int v, base, c0, r, len;
    reset = 1'b1; count_in = 4'd0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    chk_en = 1'b1;

    // Baseline only.
    hold(7, 10);
    check("baseline_total", int'(total), 0);
    check("baseline_err", int'(step_err), 0);

    // Latency: the update appears after the fifth edge following the change.
    count_in = 4'd8;
    repeat (5) @(negedge clk);
    check("latency_before", int'(total), 0);
    @(negedge clk);
    check("latency_after", int'(total), 1);
    repeat (14) @(negedge clk);
    for (int k = 9; k <= 17; k++) hold(k % 16, 20);
    check("steps_wrap_total", int'(total), 10);

    // Oversized jump.
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset2");
    reset = 1'b0;
    hold(3, 20);
    hold(12, 20);
    check("jump_err", int'(step_err), 1);
    check("jump_total", int'(total), 0);
    hold(13, 20);
    check("after_jump_total", int'(total), 1);
    check("after_jump_err", int'(step_err), 1);

    // Bouncing input is never accepted.
    hold(4, 20);
    pulse_clear();
    check("clear_total", int'(total), 0);
    check("clear_err", int'(step_err), 0);
    for (int i = 0; i < 50; i++) begin
      count_in = (i % 2 == 0) ? 4'd5 : 4'd4;
      @(negedge clk);
    end
    check("bounce_total", int'(total), 0);
    hold(5, 20);
    check("settle_total", int'(total), 1);

    // Rate: +1 every 10 cycles, window 100 cycles.
    v = 5;
    pulse_clear();
    base = tq.size();
    for (int i = 0; i < 40; i++) begin
      v = (v + 1) % 16;
      hold(v, 10);
    end
    if (tq.size() >= base + 3) begin
      check("rate_value", rq[base+2], 10);
      check("rate_period", tq[base+2] - tq[base+1], G);
    end else check("rate_pulses", tq.size() - base, 3);

    // Overflow: walk up to 65534, then add 3.
    pulse_clear();
    for (int i = 0; i < 16383; i++) begin
      v = (v + 4) % 16;
      hold(v, 3);
    end
    v = (v + 2) % 16;
    hold(v, 10);
    check("pre_ovf_total", int'(total), 65534);
    check("pre_ovf_flag", int'(total_ovf), 0);
    v = (v + 3) % 16;
    hold(v, 10);
    check("ovf_total", int'(total), 1);
    check("ovf_flag", int'(total_ovf), 1);

    // clear lands on the same edge as an accept.
    v = (v + 1) % 16;
    count_in = 4'(v);
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    c0 = cyc;
    base = tq.size();
    check("clr_accept_total", int'(total), 0);
    check("clr_accept_ovf", int'(total_ovf), 0);
    repeat (10) @(negedge clk);
    check("clr_discard_total", int'(total), 0);
    for (int i = 0; i < 200 && tq.size() == base; i++) @(negedge clk);
    if (tq.size() > base) check("clr_window_len", tq[base] - c0, G);
    else check("clr_window_timeout", 0, 1);

    // reset in the middle of a window.
    hold(v, 30);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    base = tq.size();
    for (int i = 0; i < 200 && tq.size() == base; i++) @(negedge clk);
    if (tq.size() > base) check("reset_window_len", tq[base] - c0, G);
    else check("reset_window_timeout", 0, 1);

    // Random walk with bounces, jumps, clears and resets.
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 5) pulse_clear();
      else if (r < 8) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 8);
      if (r < 60) v = (v + $urandom_range(1, 4)) % 16;
      else if (r < 75) v = (v + $urandom_range(5, 15)) % 16;
      else if (r < 85) v = v;
      else begin
        for (int j = 0; j < len; j++) begin
          count_in = 4'($urandom_range(0, 15));
          @(negedge clk);
        end
        len = 1;
      end
      hold(v, len);
    end
    hold(v, 20);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
